// File: rtl/mag_cmp_pkg.sv
// Shared types and helpers for the sequential slice-wise magnitude comparator.
package mag_cmp_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Slice counter width; a single-slice compare still needs a 1-bit counter.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mag_cmp_seq_cmp_slice.sv
// One ripple-comparator stage: folds a DIGIT-bit slice into the running gt/eq state.
module cmp_slice #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_s_i,
  input  logic [DIGIT-1:0] b_s_i,
  input  logic             gt_i,
  input  logic             eq_i,
  output logic             gt_o,
  output logic             eq_o
);

  logic s_eq;

  assign s_eq = (a_s_i == b_s_i);
  // A higher slice decides outright; an equal slice defers to the lower slices.
  assign gt_o = (a_s_i > b_s_i) | (s_eq & gt_i);
  assign eq_o = s_eq & eq_i;

endmodule

// File: rtl/mag_cmp_seq.sv
// Multi-cycle magnitude comparator: DIGIT bits per clock, LS slice first,
// unsigned or two's-complement, with a start/busy/done handshake.
module mag_cmp_seq
  import mag_cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             is_signed_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             agtb_o,
  output logic             aeqb_o,
  output logic             altb_o
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_w(N);

  if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_param_err
    $error("mag_cmp_seq: WIDTH must be a positive multiple of DIGIT");
  end

  state_e                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [N-1:0][DIGIT-1:0]  a_q, a_d;
  logic [N-1:0][DIGIT-1:0]  b_q, b_d;
  logic                     sgn_q, sgn_d;
  logic                     gt_q, gt_d;
  logic                     eq_q, eq_d;
  logic                     done_q, done_d;
  logic [2:0]               flags_q, flags_d;   // {agtb, aeqb, altb}

  logic [DIGIT-1:0]         a_s, b_s;
  logic                     last;
  logic                     gt_new, eq_new;

  assign last = (cnt_q == CW'(N - 1));

  // Offset-binary trick: flipping both sign bits turns a signed compare
  // into an unsigned one, and only the top slice holds the sign bit.
  always_comb begin
    a_s = a_q[cnt_q];
    b_s = b_q[cnt_q];
    a_s[DIGIT-1] = a_q[cnt_q][DIGIT-1] ^ (sgn_q & last);
    b_s[DIGIT-1] = b_q[cnt_q][DIGIT-1] ^ (sgn_q & last);
  end

  cmp_slice #(.DIGIT(DIGIT)) u_slice (
    .a_s_i (a_s),
    .b_s_i (b_s),
    .gt_i  (gt_q),
    .eq_i  (eq_q),
    .gt_o  (gt_new),
    .eq_o  (eq_new)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    done_d  = 1'b0;
    flags_d = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          a_d     = a_i;
          b_d     = b_i;
          sgn_d   = is_signed_i;
          gt_d    = 1'b0;
          eq_d    = 1'b1;
        end
      end
      ST_RUN: begin
        gt_d = gt_new;
        eq_d = eq_new;
        if (last) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          flags_d = {gt_new, eq_new, ~gt_new & ~eq_new};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b1;
      done_q  <= 1'b0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      done_q  <= done_d;
      flags_q <= flags_d;
    end
  end

  assign busy_o = (state_q == ST_RUN);
  assign done_o = done_q;
  assign agtb_o = flags_q[2];
  assign aeqb_o = flags_q[1];
  assign altb_o = flags_q[0];

endmodule

// File: tb/tb_mag_cmp_seq.sv
// Directed bench for mag_cmp_seq at default parameters (WIDTH=16, DIGIT=4, N=4).
module tb_mag_cmp_seq;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] a, b;
  logic        is_signed;
  logic        busy, done, agtb, aeqb, altb;

  int total  = 0;
  int passed = 0;

  mag_cmp_seq #(.WIDTH(16), .DIGIT(4)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .start_i     (start),
    .a_i         (a),
    .b_i         (b),
    .is_signed_i (is_signed),
    .busy_o      (busy),
    .done_o      (done),
    .agtb_o      (agtb),
    .aeqb_o      (aeqb),
    .altb_o      (altb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Accept on the next edge, then check every cycle up to and including done.
  // prev = flags expected to hold during RUN, exp = flags after done.
  task automatic run_cmp(input logic [15:0] av, input logic [15:0] bv, input logic s,
                         input logic [2:0] exp, input logic [2:0] prev, input string tag);
    @(negedge clk);
    a = av; b = bv; is_signed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); is_signed = ~s;
    chk({tag, ".busy0"}, 32'(busy), 32'd1);
    for (int i = 1; i <= N; i++) begin
      @(posedge clk); #1;
      if (i < N) begin
        chk({tag, ".busy_run"}, 32'(busy), 32'd1);
        chk({tag, ".done_early"}, 32'(done), 32'd0);
        chk({tag, ".hold"}, 32'({agtb, aeqb, altb}), 32'(prev));
      end else begin
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".busy_end"}, 32'(busy), 32'd0);
        chk({tag, ".flags"}, 32'({agtb, aeqb, altb}), 32'(exp));
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; is_signed = 1'b0;
    #12;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.flags", 32'({agtb, aeqb, altb}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle.busy", 32'(busy), 32'd0);
    chk("idle.flags", 32'({agtb, aeqb, altb}), 32'd0);

    run_cmp(16'h8000, 16'h7FFF, 1'b0, 3'b100, 3'b000, "u8000");
    run_cmp(16'h8000, 16'h7FFF, 1'b1, 3'b001, 3'b100, "s8000");
    run_cmp(16'hFFFF, 16'h0000, 1'b1, 3'b001, 3'b001, "sFFFF");
    run_cmp(16'hFFFF, 16'h0000, 1'b0, 3'b100, 3'b001, "uFFFF");
    run_cmp(16'h0001, 16'h0000, 1'b0, 3'b100, 3'b100, "lsb");
    run_cmp(16'h1000, 16'h0FFF, 1'b0, 3'b100, 3'b100, "carry");
    run_cmp(16'hA5A5, 16'hA5A5, 1'b0, 3'b010, 3'b100, "eq");

    // start while busy must not re-latch operands
    @(negedge clk);
    a = 16'd1; b = 16'd2; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    chk("sb.hold", 32'({agtb, aeqb, altb}), 32'b010);
    start = 1'b1; a = 16'd9; b = 16'd2;
    @(posedge clk); #1; start = 1'b0;
    chk("sb.busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("sb.done_early", 32'(done), 32'd0);
    @(posedge clk); #1;
    chk("sb.done", 32'(done), 32'd1);
    chk("sb.flags", 32'({agtb, aeqb, altb}), 32'b001);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("sb.no_second_done", 32'(done), 32'd0);
      chk("sb.idle", 32'(busy), 32'd0);
    end

    // reset in the middle of RUN aborts without done
    @(negedge clk);
    a = 16'd5; b = 16'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mr.busy", 32'(busy), 32'd0);
    chk("mr.done", 32'(done), 32'd0);
    chk("mr.flags", 32'({agtb, aeqb, altb}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("mr.no_done", 32'(done), 32'd0);
      chk("mr.flags_after", 32'({agtb, aeqb, altb}), 32'd0);
    end
    run_cmp(16'h0000, 16'h0000, 1'b0, 3'b010, 3'b000, "mr.zero");

    // back-to-back: second start lands in the done cycle of the first
    run_cmp(16'd7, 16'd3, 1'b0, 3'b100, 3'b010, "b2b.1");
    run_cmp(16'd3, 16'd3, 1'b0, 3'b010, 3'b100, "b2b.2");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
